// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: FSM state codes,
// default parameters and the word-alignment helper.
package mem_access_ctrl_pkg;

    localparam int          DATA_W_DEF   = 32;
    localparam int          TIMEOUT_DEF  = 255;
    localparam logic [31:0] BAD_DATA_DEF = 32'hDEADBEEF;

    typedef logic [1:0] memState_t;

    // Encodings are shared with the hazard unit, so they must not be renumbered.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic isWordAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit wait counter for the memory request phase; hit_o flags that the
// request has been outstanding for TIMEOUT cycles.
module mem_timeout_ctr
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic hit_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == 8'(TIMEOUT));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: converts EMReg load/store outputs into a req/ack
// transaction with a multi-cycle data memory, stalling the pipeline meanwhile.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                TIMEOUT  = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] BAD_DATA = DATA_W'(BAD_DATA_DEF)
)
(
    input  logic              Clk_i,
    input  logic              Reset_n_i,
    input  logic              MemtoRegM_i,
    input  logic              MemWriteM_i,
    input  logic [DATA_W-1:0] ExecuteOutM_i,
    input  logic [DATA_W-1:0] WriteDataM_i,
    output logic              StallM_o,
    output logic [DATA_W-1:0] ReadDataM_o,
    output logic              ReadValidM_o,
    output logic              MemErr_o,
    output logic              MemReq_o,
    output logic              MemWe_o,
    output logic [DATA_W-1:0] MemAddr_o,
    output logic [DATA_W-1:0] MemWData_o,
    input  logic [DATA_W-1:0] MemRData_i,
    input  logic              MemAck_i
);

    memState_t         state_q,     state_d;
    logic              memReq_q,    memReq_d;
    logic              memWe_q,     memWe_d;
    logic [DATA_W-1:0] memAddr_q,   memAddr_d;
    logic [DATA_W-1:0] memWData_q,  memWData_d;
    logic [DATA_W-1:0] readData_q,  readData_d;
    logic              readValid_q, readValid_d;
    logic              memErr_q,    memErr_d;
    logic              isLoad_q,    isLoad_d;

    logic access;
    logic aligned;
    logic launch;
    logic ctrHit;

    assign access  = MemtoRegM_i | MemWriteM_i;
    assign aligned = isWordAligned(ExecuteOutM_i[1:0]);
    assign launch  = (state_q == ST_IDLE) && access && aligned;

    // The counter already reads 1 in the first REQ cycle, so hit lands on REQ cycle TIMEOUT.
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (Clk_i),
        .rst_n_i (Reset_n_i),
        .clear_i ((state_q != ST_REQ) && !launch),
        .en_i    (launch || (state_q == ST_REQ)),
        .hit_o   (ctrHit)
    );

    always_comb begin
        state_d     = state_q;
        memReq_d    = memReq_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWData_d  = memWData_q;
        readData_d  = readData_q;
        readValid_d = 1'b0;
        memErr_d    = memErr_q;
        isLoad_d    = isLoad_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // A simultaneous load+store is executed as the store alone.
                    isLoad_d   = MemtoRegM_i & ~MemWriteM_i;
                    readData_d = '0;
                    if (aligned) begin
                        memAddr_d  = {ExecuteOutM_i[DATA_W-1:2], 2'b00};
                        memWData_d = WriteDataM_i;
                        memWe_d    = MemWriteM_i;
                        memReq_d   = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        memErr_d    = 1'b1;
                        readData_d  = BAD_DATA;
                        readValid_d = MemtoRegM_i & ~MemWriteM_i;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (MemAck_i) begin
                    memReq_d    = 1'b0;
                    readValid_d = isLoad_q;
                    if (isLoad_q) begin
                        readData_d = MemRData_i;
                    end
                    state_d = ST_DONE;
                end else if (ctrHit) begin
                    memReq_d    = 1'b0;
                    memErr_d    = 1'b1;
                    readData_d  = BAD_DATA;
                    readValid_d = isLoad_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q     <= ST_IDLE;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWData_q  <= '0;
            readData_q  <= '0;
            readValid_q <= 1'b0;
            memErr_q    <= 1'b0;
            isLoad_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWData_q  <= memWData_d;
            readData_q  <= readData_d;
            readValid_q <= readValid_d;
            memErr_q    <= memErr_d;
            isLoad_q    <= isLoad_d;
        end
    end

    // DONE releases the stall so EMReg advances on the edge that returns us to IDLE.
    assign StallM_o     = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ);
    assign ReadDataM_o  = readData_q;
    assign ReadValidM_o = readValid_q;
    assign MemErr_o     = memErr_q;
    assign MemReq_o     = memReq_q;
    assign MemWe_o      = memWe_q;
    assign MemAddr_o    = memAddr_q;
    assign MemWData_o   = memWData_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios then random instructions, each
// checked against a transaction-level model of stall, request and result.
module tb_mem_access_ctrl;

    localparam logic [31:0] BAD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetN;
    logic        memtoRegM;
    logic        memWriteM;
    logic [31:0] executeOutM;
    logic [31:0] writeDataM;
    logic        stallM;
    logic [31:0] readDataM;
    logic        readValidM;
    logic        memErr;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    int   compareCount  = 0;
    int   mismatchCount = 0;
    logic expErr        = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .Clk_i         (clk),
        .Reset_n_i     (resetN),
        .MemtoRegM_i   (memtoRegM),
        .MemWriteM_i   (memWriteM),
        .ExecuteOutM_i (executeOutM),
        .WriteDataM_i  (writeDataM),
        .StallM_o      (stallM),
        .ReadDataM_o   (readDataM),
        .ReadValidM_o  (readValidM),
        .MemErr_o      (memErr),
        .MemReq_o      (memReq),
        .MemWe_o       (memWe),
        .MemAddr_o     (memAddr),
        .MemWData_o    (memWData),
        .MemRData_i    (memRData),
        .MemAck_i      (memAck)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One instruction held in EMReg until StallM drops; ackWait<0 means memory never answers.
    task automatic applyStimulus(input logic load, input logic store, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ackWait,
                                 input logic [31:0] rdata, input logic stray);
        logic        access, aligned, expLoad, timedOut, done, stable;
        logic [31:0] expData;
        int          expReqs, stalls, reqs, cycles;

        access   = load | store;
        aligned  = (addr[1:0] == 2'b00);
        expLoad  = load & ~store;
        timedOut = access && aligned && (ackWait < 0);
        if (!access || !aligned) expReqs = 0;
        else if (ackWait < 0)    expReqs = 255;
        else                     expReqs = ackWait + 1;
        if (access && (!aligned || timedOut)) begin
            expErr  = 1'b1;
            expData = BAD;
        end else if (access && expLoad) begin
            expData = rdata;
        end else begin
            expData = 32'h0;
        end

        @(negedge clk);
        memtoRegM   = load;
        memWriteM   = store;
        executeOutM = addr;
        writeDataM  = wdata;
        stalls = 0; reqs = 0; cycles = 0; done = 1'b0; stable = 1'b1;
        while (!done && cycles < 600) begin
            #1;
            if (memReq) begin
                reqs++;
                if (memAddr !== addr || memWData !== wdata || memWe !== store) stable = 1'b0;
                memAck   = (ackWait >= 0) && (reqs == ackWait + 1);
                memRData = memAck ? rdata : $urandom;
            end else begin
                memAck   = stray;
                memRData = $urandom;
            end
            if (stallM) stalls++;
            else        done = 1'b1;
            cycles++;
            if (!done) @(negedge clk);
        end

        checkOutput("budget", 32'(done), 32'd1);
        checkOutput("stallCycles", stalls, access ? expReqs + 1 : 0);
        checkOutput("reqCycles", reqs, expReqs);
        if (reqs > 0) checkOutput("reqStable", 32'(stable), 32'd1);
        if (access) begin
            checkOutput("readValid", 32'(readValidM), 32'(expLoad));
            checkOutput("readData", readDataM, expData);
        end else begin
            checkOutput("idleValid", 32'(readValidM), 32'd0);
        end
        checkOutput("memErr", 32'(memErr), 32'(expErr));
    endtask

    task automatic resetMidReq();
        @(negedge clk);
        memtoRegM   = 1'b1;
        memWriteM   = 1'b0;
        executeOutM = 32'h0000_0300;
        memAck      = 1'b0;
        @(negedge clk);
        #1 checkOutput("rstReqCycle1", 32'(memReq), 32'd1);
        @(negedge clk);
        #1 checkOutput("rstReqCycle2", 32'(memReq), 32'd1);
        resetN = 1'b0;
        @(negedge clk);
        resetN    = 1'b1;
        memtoRegM = 1'b0;
        memAck    = 1'b1;
        memRData  = 32'h5555_AAAA;
        expErr    = 1'b0;
        #1;
        checkOutput("rstReqDropped", 32'(memReq), 32'd0);
        checkOutput("rstStall", 32'(stallM), 32'd0);
        checkOutput("rstErrCleared", 32'(memErr), 32'd0);
        @(negedge clk);
        memAck = 1'b0;
        #1;
        checkOutput("lateAckReq", 32'(memReq), 32'd0);
        checkOutput("lateAckValid", 32'(readValidM), 32'd0);
        checkOutput("lateAckData", readDataM, 32'h0);
        checkOutput("lateAckStall", 32'(stallM), 32'd0);
    endtask

    initial begin
        int          op, pick, ackWait;
        logic [31:0] addr;

        resetN      = 1'b0;
        memtoRegM   = 1'b0;
        memWriteM   = 1'b0;
        executeOutM = 32'h0;
        writeDataM  = 32'h0;
        memRData    = 32'h0;
        memAck      = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("rstStallM", 32'(stallM), 32'd0);
        checkOutput("rstMemReq", 32'(memReq), 32'd0);
        checkOutput("rstMemWe", 32'(memWe), 32'd0);
        checkOutput("rstMemAddr", memAddr, 32'h0);
        checkOutput("rstMemWData", memWData, 32'h0);
        checkOutput("rstReadData", readDataM, 32'h0);
        checkOutput("rstReadValid", 32'(readValidM), 32'd0);
        checkOutput("rstMemErr", 32'(memErr), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, $urandom, $urandom, 0, 32'h0, 1'(i));
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, -1, 32'h0, 1'b0);
        resetMidReq();
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0, 254, 32'hA5A5_0001, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op   = $urandom_range(0, 3);
            addr = $urandom;
            addr[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pick = $urandom_range(0, 19);
            if (pick == 0)      ackWait = -1;
            else if (pick == 1) ackWait = 254;
            else                ackWait = $urandom_range(0, 6);
            applyStimulus(op[0], op[1], addr, $urandom, ackWait, $urandom, 1'($urandom_range(0, 1)));
        end

        memAck = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
